// File: rtl/alu_pkg.sv
// Shared execute-stage ALU definitions.
// Multiply op encoding matches funct3[1:0] of the RV32M/RV64M multiply group.
package alu_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    // Operand A is sign-extended for the two signed-A high-half modes.
    function automatic logic mul_a_signed(input logic [1:0] op);
        return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    endfunction

    // Operand B is signed only for MULH.
    function automatic logic mul_b_signed(input logic [1:0] op);
        return (op == MUL_OP_MULH);
    endfunction

endpackage

// File: rtl/mul_pp_gen.sv
// Purpose: WIDTH-row partial-product generator with per-mode sign handling.
// Latency: combinational, feeds the stage P registers of alu_mul_pipe.
// Backpressure: none; the enclosing pipeline enable decides when rows are captured.
module mul_pp_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]                a,
    input  logic [WIDTH-1:0]                b,
    input  logic [1:0]                      op,
    output logic [WIDTH-1:0][2*WIDTH-1:0]   rows
);

    logic [2*WIDTH-1:0] a_ext;

    assign a_ext = {{WIDTH{mul_a_signed(op) & a[WIDTH-1]}}, a};

    // A signed B contributes -2^(WIDTH-1) for its top bit, so that row is negated.
    always_comb begin
        rows = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rows[i] = b[i] ? (a_ext << i) : '0;
        end
        if (mul_b_signed(op)) begin
            rows[WIDTH-1] = -rows[WIDTH-1];
        end
    end

endmodule

// File: rtl/alu_mul_pipe.sv
// Purpose: fully pipelined WIDTH x WIDTH multiplier (MUL/MULH/MULHSU/MULHU) with tag pass-through.
// Latency: log2(WIDTH)+1 cycles, one op per cycle.
// Backpressure: single global enable; all stages hold while out_valid && !out_ready, in_ready drops.
module alu_mul_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  src_A,
    input  logic [WIDTH-1:0]  src_B,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [TAG_W-1:0]  tag_out,
    output logic              busy
);

    localparam int K    = $clog2(WIDTH);
    localparam int LAT  = K + 1;
    localparam int NSTG = LAT - 1;
    localparam int PW   = 2 * WIDTH;
    localparam int NROW = 2 * WIDTH - 2;

    // Level l of the tree keeps WIDTH>>l rows, packed back to back in rows_q.
    function automatic int row_base(input int lvl);
        return (2 * WIDTH) - ((2 * WIDTH) >> lvl);
    endfunction

    logic                          en;
    logic [WIDTH-1:0][PW-1:0]      pp;
    logic [NROW-1:0][PW-1:0]       rows_q;
    logic [NSTG-1:0]               vld_q;
    logic [NSTG-1:0][1:0]          op_q;
    logic [NSTG-1:0][TAG_W-1:0]    tag_q;
    logic [PW-1:0]                 prod;

    assign en       = !out_valid || out_ready;
    assign in_ready = en && rst && !flush;
    assign busy     = (|vld_q) || out_valid;

    mul_pp_gen #(
        .WIDTH (WIDTH)
    ) u_pp_gen (
        .a    (src_A),
        .b    (src_B),
        .op   (op),
        .rows (pp)
    );

    // Stage P: data registers carry no reset, only the valid chain matters.
    always_ff @(posedge clk) begin
        if (en) begin
            rows_q[WIDTH-1:0] <= pp;
            op_q[0]           <= op;
            tag_q[0]          <= tag_in;
        end
    end

    for (genvar l = 1; l < NSTG; l++) begin : g_lvl
        localparam int N  = WIDTH >> l;
        localparam int BS = row_base(l);
        localparam int PB = row_base(l - 1);

        for (genvar r = 0; r < N; r++) begin : g_row
            always_ff @(posedge clk) begin
                if (en) begin
                    rows_q[BS+r] <= rows_q[PB+2*r] + rows_q[PB+2*r+1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (en) begin
                op_q[l]  <= op_q[l-1];
                tag_q[l] <= tag_q[l-1];
            end
        end
    end

    // Final pair of rows is summed straight into the output register.
    assign prod = rows_q[NROW-2] + rows_q[NROW-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q     <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            tag_out   <= '0;
        end else if (flush) begin
            vld_q     <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            vld_q     <= {vld_q[NSTG-2:0], in_valid};
            out_valid <= vld_q[NSTG-1];
            result    <= (op_q[NSTG-1] == MUL_OP_MUL) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
            tag_out   <= tag_q[NSTG-1];
        end
    end

endmodule

// File: tb/tb_alu_mul_pipe.sv
// Self-checking bench for alu_mul_pipe at WIDTH=32, plus WIDTH=8 and WIDTH=64 random regressions.
module tb_alu_mul_pipe;

    localparam int W   = 32;
    localparam int LAT = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready, in_ready, out_valid, busy;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, result;
    logic [4:0]  tag_in, tag_out;

    logic        fl_off;
    logic        iv8, ir8, ov8, or8, by8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, r8;
    logic [4:0]  ti8, to8;
    logic        iv64, ir64, ov64, or64, by64;
    logic [1:0]  op64;
    logic [63:0] a64, b64, r64;
    logic [4:0]  ti64, to64;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  tag;
    } exp_t;

    exp_t sb[$];
    exp_t q8[$];
    exp_t q64[$];

    logic [1:0]  d_op  [6] = '{2'b00, 2'b11, 2'b00, 2'b01, 2'b01, 2'b10};
    logic [31:0] d_a   [6] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] d_b   [6] = '{32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] d_exp [6] = '{32'd42, 32'hFFFFFFFE, 32'h00000001, 32'h40000000, 32'h00000000, 32'hFFFFFFFF};

    alu_mul_pipe #(.WIDTH(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src_A(src_a), .src_B(src_b), .tag_in(tag_in), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .tag_out(tag_out), .busy(busy)
    );

    alu_mul_pipe #(.WIDTH(8), .TAG_W(5)) dut8 (
        .clk(clk), .rst(rst), .flush(fl_off), .in_valid(iv8), .in_ready(ir8),
        .op(op8), .src_A(a8), .src_B(b8), .tag_in(ti8), .out_valid(ov8),
        .out_ready(or8), .result(r8), .tag_out(to8), .busy(by8)
    );

    alu_mul_pipe #(.WIDTH(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst), .flush(fl_off), .in_valid(iv64), .in_ready(ir64),
        .op(op64), .src_A(a64), .src_B(b64), .tag_in(ti64), .out_valid(ov64),
        .out_ready(or64), .result(r64), .tag_out(to64), .busy(by64)
    );

    // Reference: extend both operands to 128 bits per mode, multiply, pick the half.
    function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic [63:0] a,
                                            input logic [63:0] b, input int w);
        logic [127:0] m, ax, bx, p, hi;
        m  = (128'd1 << w) - 128'd1;
        ax = {64'd0, a} & m;
        bx = {64'd0, b} & m;
        if ((o == 2'b01 || o == 2'b10) && a[w-1]) ax = ax | ~m;
        if (o == 2'b01 && b[w-1]) bx = bx | ~m;
        p  = ax * bx;
        hi = (p >> w) & m;
        return (o == 2'b00) ? (p[63:0] & m[63:0]) : hi[63:0];
    endfunction

    // Samples the handshake before the edge, updates the scoreboard, advances one cycle.
    task automatic step(output bit dlv, output logic [31:0] r, output logic [4:0] t);
        exp_t e;
        #1;
        dlv = out_valid && out_ready && rst && !flush;
        r   = result;
        t   = tag_out;
        if (in_valid && in_ready) begin
            e.res = ref_mul(op, {32'd0, src_a}, {32'd0, src_b}, W);
            e.tag = tag_in;
            sb.push_back(e);
        end
        if (flush || !rst) sb.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_op();
        op     = 2'($urandom_range(0, 3));
        src_a  = $urandom;
        src_b  = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; op = 2'b00;
        src_a = 32'd3; src_b = 32'd4; tag_in = 5'd7;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        checks++; if (tag_out !== 5'd0) begin errors++; $display("FAIL reset_tag_out: got %0d want 0", tag_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (ov8 !== 1'b0 || ov64 !== 1'b0) begin errors++; $display("FAIL reset_other_widths: got %b/%b want 0/0", ov8, ov64); end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_directed();
        bit dlv, seen;
        logic [31:0] r;
        logic [4:0] t;
        exp_t e;
        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            op = d_op[v]; src_a = d_a[v]; src_b = d_b[v]; tag_in = 5'(v); in_valid = 1'b1;
            step(dlv, r, t);
            in_valid = 1'b0;
            seen = 1'b0;
            for (int n = 1; n <= LAT + 4 && !seen; n++) begin
                step(dlv, r, t);
                if (dlv) begin
                    seen = 1'b1;
                    if (sb.size() != 0) e = sb.pop_front();
                    checks++; if (n != LAT) begin errors++; $display("FAIL directed_latency[%0d]: got %0d cycles want %0d", v, n, LAT); end
                    checks++; if (r !== d_exp[v] || t !== 5'(v)) begin errors++; $display("FAIL directed_result[%0d]: got %h tag %0d want %h tag %0d", v, r, t, d_exp[v], v); end
                end
            end
            if (!seen) begin checks++; errors++; $display("FAIL directed_timeout[%0d]: got no out_valid want one", v); end
        end
    endtask

    task automatic test_back_to_back();
        bit dlv, acc;
        logic [31:0] r;
        logic [4:0] t;
        exp_t e;
        int sent = 0, ndel = 0, first = -1, last = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 80 && ndel < 20; c++) begin
            in_valid = (sent < 20);
            if (in_valid) begin rand_op(); tag_in = 5'(sent); end
            #1;
            acc = in_valid && in_ready;
            step(dlv, r, t);
            if (acc) sent++;
            if (dlv) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL b2b_unexpected: got %h tag %0d want none", r, t); end
                else begin
                    e = sb.pop_front();
                    if (r !== e.res[31:0] || t !== e.tag || t !== 5'(ndel)) begin
                        errors++; $display("FAIL b2b_result[%0d]: got %h tag %0d want %h tag %0d", ndel, r, t, e.res[31:0], e.tag);
                    end
                end
                if (first < 0) first = c;
                last = c;
                ndel++;
            end
        end
        in_valid = 1'b0;
        checks++; if (ndel != 20) begin errors++; $display("FAIL b2b_count: got %0d want 20", ndel); end
        checks++; if (last - first != 19) begin errors++; $display("FAIL b2b_rate: got span %0d want 19", last - first); end
    endtask

    task automatic test_backpressure();
        bit dlv, acc;
        logic [31:0] r, held_r;
        logic [4:0] t;
        exp_t e;
        int sent = 0, ndel = 0, stalled = 0;
        held_r = '0;
        rand_op(); tag_in = 5'd0;
        for (int c = 0; c < 80 && ndel < 10; c++) begin
            in_valid = (sent < 10);
            #1;
            if ((stalled == 0 && out_valid && tag_out == 5'd3) || (stalled > 0 && stalled < 4)) begin
                out_ready = 1'b0;
                #1;
                if (stalled == 0) held_r = result;
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== held_r || tag_out !== 5'd3) begin
                    errors++; $display("FAIL stall_hold[%0d]: got rdy %b vld %b %h tag %0d want 0 1 %h 3", stalled, in_ready, out_valid, result, tag_out, held_r);
                end
                stalled++;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            acc = in_valid && in_ready;
            step(dlv, r, t);
            if (acc) begin sent++; rand_op(); tag_in = 5'(sent); end
            if (dlv) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL stall_unexpected: got %h tag %0d want none", r, t); end
                else begin
                    e = sb.pop_front();
                    if (r !== e.res[31:0] || t !== e.tag) begin errors++; $display("FAIL stall_result: got %h tag %0d want %h tag %0d", r, t, e.res[31:0], e.tag); end
                end
                ndel++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (ndel != 10 || sb.size() != 0) begin errors++; $display("FAIL stall_count: got %0d delivered %0d left want 10 0", ndel, sb.size()); end
        checks++; if (stalled != 4) begin errors++; $display("FAIL stall_cycles: got %0d want 4", stalled); end
    endtask

    task automatic test_flush();
        bit dlv;
        logic [31:0] r;
        logic [4:0] t;
        exp_t e;
        int ndel = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; rand_op(); tag_in = 5'(20 + i);
            step(dlv, r, t);
        end
        rand_op(); tag_in = 5'd23; flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        step(dlv, r, t);
        flush = 1'b0;
        op = 2'b00; src_a = 32'd5; src_b = 32'd5; tag_in = 5'd24;
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_cleared: got busy %b vld %b want 0 0", busy, out_valid); end
        step(dlv, r, t);
        in_valid = 1'b0;
        for (int n = 1; n <= LAT + 4; n++) begin
            step(dlv, r, t);
            if (dlv) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL flush_unexpected: got %h tag %0d want none", r, t); end
                else begin
                    e = sb.pop_front();
                    if (n != LAT || r !== 32'd25 || t !== 5'd24) begin
                        errors++; $display("FAIL flush_after: got %h tag %0d at %0d want 00000019 tag 24 at %0d", r, t, n, LAT);
                    end
                end
                ndel++;
            end
        end
        checks++; if (ndel != 1) begin errors++; $display("FAIL flush_count: got %0d want 1", ndel); end
    endtask

    task automatic test_reset_mid();
        bit dlv;
        logic [31:0] r;
        logic [4:0] t;
        exp_t e;
        int extra = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; rand_op(); tag_in = 5'(i);
            step(dlv, r, t);
            if (dlv) begin
                checks++;
                e = (sb.size() != 0) ? sb.pop_front() : '0;
                if (r !== e.res[31:0] || t !== e.tag) begin errors++; $display("FAIL rstmid_pre: got %h tag %0d want %h tag %0d", r, t, e.res[31:0], e.tag); end
            end
        end
        rst = 1'b0;
        step(dlv, r, t);
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_state: got vld %b res %h busy %b rdy %b want 0 0 0 0", out_valid, result, busy, in_ready);
        end
        rst = 1'b1; in_valid = 1'b0;
        for (int n = 0; n < LAT + 3; n++) begin
            step(dlv, r, t);
            if (dlv) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL rstmid_stale: got %0d outputs want 0", extra); end
    endtask

    task automatic test_widths();
        bit acc8, acc64, dl8, dl64;
        logic [7:0]  s8;
        logic [63:0] s64;
        logic [4:0]  st8, st64;
        exp_t e;
        int n_in8 = 0, n_out8 = 0, n_in64 = 0, n_out64 = 0;
        for (int c = 0; c < 500; c++) begin
            iv8  = (c < 380) && ($urandom_range(0, 3) != 0);
            iv64 = (c < 380) && ($urandom_range(0, 3) != 0);
            or8  = (c >= 380) || ($urandom_range(0, 3) != 0);
            or64 = (c >= 380) || ($urandom_range(0, 3) != 0);
            op8  = 2'($urandom_range(0, 3));
            op64 = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: begin a8 = 8'hFF; a64 = '1; end
                1: begin a8 = 8'h80; a64 = 64'h8000_0000_0000_0000; end
                default: begin a8 = 8'($urandom); a64 = {$urandom, $urandom}; end
            endcase
            case ($urandom_range(0, 3))
                0: begin b8 = 8'hFF; b64 = '1; end
                1: begin b8 = 8'h80; b64 = 64'h8000_0000_0000_0000; end
                default: begin b8 = 8'($urandom); b64 = {$urandom, $urandom}; end
            endcase
            ti8 = 5'($urandom); ti64 = 5'($urandom);
            #1;
            acc8 = iv8 && ir8;   dl8 = ov8 && or8;   s8 = r8;   st8 = to8;
            acc64 = iv64 && ir64; dl64 = ov64 && or64; s64 = r64; st64 = to64;
            if (acc8) begin e.res = ref_mul(op8, {56'd0, a8}, {56'd0, b8}, 8); e.tag = ti8; q8.push_back(e); n_in8++; end
            if (acc64) begin e.res = ref_mul(op64, a64, b64, 64); e.tag = ti64; q64.push_back(e); n_in64++; end
            @(posedge clk);
            @(negedge clk);
            if (dl8) begin
                checks++; n_out8++;
                e = (q8.size() != 0) ? q8.pop_front() : '0;
                if (s8 !== e.res[7:0] || st8 !== e.tag) begin errors++; $display("FAIL w8_result: got %h tag %0d want %h tag %0d", s8, st8, e.res[7:0], e.tag); end
            end
            if (dl64) begin
                checks++; n_out64++;
                e = (q64.size() != 0) ? q64.pop_front() : '0;
                if (s64 !== e.res || st64 !== e.tag) begin errors++; $display("FAIL w64_result: got %h tag %0d want %h tag %0d", s64, st64, e.res, e.tag); end
            end
        end
        iv8 = 1'b0; iv64 = 1'b0;
        checks++; if (n_out8 != n_in8 || q8.size() != 0) begin errors++; $display("FAIL w8_count: got %0d out want %0d", n_out8, n_in8); end
        checks++; if (n_out64 != n_in64 || q64.size() != 0) begin errors++; $display("FAIL w64_count: got %0d out want %0d", n_out64, n_in64); end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 2'b00; src_a = '0; src_b = '0; tag_in = '0; fl_off = 1'b0;
        iv8 = 1'b0; or8 = 1'b1; op8 = 2'b00; a8 = '0; b8 = '0; ti8 = '0;
        iv64 = 1'b0; or64 = 1'b1; op64 = 2'b00; a64 = '0; b64 = '0; ti64 = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_widths();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
